// File: rtl/lsu_bus_clken_gen_pkg.sv
// Shared LSU bus-clock definitions: ratio width and the ratio-change FSM states.
package lsu_bus_clken_gen_pkg;

    localparam int LSU_BUS_RATIO_W = 3;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        APPLY = 2'd2
    } lsu_busratio_state_t;

endpackage

// File: rtl/lsu_bus_clken_cnt.sv
// Core:bus divider counter producing the bus-edge enable and its one-cycle delayed copy.
module lsu_bus_clken_cnt
    import lsu_bus_clken_gen_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_l,
    input  logic [LSU_BUS_RATIO_W-1:0] ratio,
    input  logic                       restart,
    input  logic                       override,
    output logic                       bus_edge,
    output logic                       en,
    output logic                       en_q
);

    logic [LSU_BUS_RATIO_W-1:0] cnt_reg;

    assign bus_edge = (cnt_reg == ratio);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            cnt_reg <= '0;
            en      <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            en_q <= en;
            // A restart realigns the phase so the new ratio starts counting from zero.
            if (restart) begin
                cnt_reg <= '0;
                en      <= override;
            end else begin
                cnt_reg <= bus_edge ? '0 : cnt_reg + 1'b1;
                en      <= bus_edge | override;
            end
        end
    end

endmodule

// File: rtl/lsu_bus_clken_gen.sv
// Bus clock enable generator with a programmable 1:1..1:8 ratio changed via a drained valid/ready request.
module lsu_bus_clken_gen
    import lsu_bus_clken_gen_pkg::*;
#(
    parameter logic [LSU_BUS_RATIO_W-1:0] DEFAULT_RATIO = '0,
    parameter int                         DRAIN_MAX     = 16
) (
    input  logic                       clk,
    input  logic                       rst_l,
    input  logic                       clk_override,
    input  logic                       lsu_bus_idle,
    input  logic                       ratio_wr_valid,
    input  logic [LSU_BUS_RATIO_W-1:0] ratio_wr_data,
    output logic                       ratio_wr_ready,
    output logic                       ratio_wr_ack,
    output logic                       ratio_wr_err,
    output logic [LSU_BUS_RATIO_W-1:0] bus_clk_ratio,
    output logic                       lsu_bus_clk_en,
    output logic                       lsu_bus_clk_en_q
);

    localparam int DCW = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_MAX - 1);

    lsu_busratio_state_t        state_reg;
    logic [LSU_BUS_RATIO_W-1:0] pending_reg;
    logic [DCW-1:0]             drain_cnt_reg;
    logic                       bus_edge;

    assign ratio_wr_ready = (state_reg == RUN);

    lsu_bus_clken_cnt u_cnt (
        .clk      (clk),
        .rst_l    (rst_l),
        .ratio    (bus_clk_ratio),
        .restart  (state_reg == APPLY),
        .override (clk_override),
        .bus_edge (bus_edge),
        .en       (lsu_bus_clk_en),
        .en_q     (lsu_bus_clk_en_q)
    );

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_reg     <= RUN;
            pending_reg   <= DEFAULT_RATIO;
            drain_cnt_reg <= '0;
            bus_clk_ratio <= DEFAULT_RATIO;
            ratio_wr_ack  <= 1'b0;
            ratio_wr_err  <= 1'b0;
        end else begin
            ratio_wr_ack <= 1'b0;
            ratio_wr_err <= 1'b0;
            case (state_reg)
                RUN: begin
                    if (ratio_wr_valid) begin
                        pending_reg   <= ratio_wr_data;
                        drain_cnt_reg <= '0;
                        state_reg     <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Only real counter edges count; idle on the final edge still applies.
                    if (bus_edge) begin
                        if (lsu_bus_idle) begin
                            state_reg <= APPLY;
                        end else if (drain_cnt_reg == DRAIN_LAST) begin
                            state_reg    <= RUN;
                            ratio_wr_ack <= 1'b1;
                            ratio_wr_err <= 1'b1;
                        end else begin
                            drain_cnt_reg <= drain_cnt_reg + 1'b1;
                        end
                    end
                end
                APPLY: begin
                    bus_clk_ratio <= pending_reg;
                    ratio_wr_ack  <= 1'b1;
                    state_reg     <= RUN;
                end
                default: state_reg <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus_clken_gen.sv
// Randomized and directed checks of lsu_bus_clken_gen against a cycle-indexed behavioural model.
module tb_lsu_bus_clken_gen;

    localparam logic [2:0] DEF_R = 3'd3;
    localparam int DMAX = 16;

    logic       clk = 1'b0;
    logic       rst_l = 1'b0;
    logic       clk_override = 1'b0;
    logic       lsu_bus_idle = 1'b1;
    logic       ratio_wr_valid = 1'b0;
    logic [2:0] ratio_wr_data = 3'd0;
    logic       ratio_wr_ready;
    logic       ratio_wr_ack;
    logic       ratio_wr_err;
    logic [2:0] bus_clk_ratio;
    logic       lsu_bus_clk_en;
    logic       lsu_bus_clk_en_q;

    always #5 clk = ~clk;

    lsu_bus_clken_gen #(.DEFAULT_RATIO(DEF_R), .DRAIN_MAX(DMAX)) dut (
        .clk              (clk),
        .rst_l            (rst_l),
        .clk_override     (clk_override),
        .lsu_bus_idle     (lsu_bus_idle),
        .ratio_wr_valid   (ratio_wr_valid),
        .ratio_wr_data    (ratio_wr_data),
        .ratio_wr_ready   (ratio_wr_ready),
        .ratio_wr_ack     (ratio_wr_ack),
        .ratio_wr_err     (ratio_wr_err),
        .bus_clk_ratio    (bus_clk_ratio),
        .lsu_bus_clk_en   (lsu_bus_clk_en),
        .lsu_bus_clk_en_q (lsu_bus_clk_en_q)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: the phase is described by an origin cycle (where the divider was at
    // zero) and the ratio; a bus edge is any cycle whose offset is D-1 mod D.
    int   m_t, m_o, m_r, m_pend, m_drains;
    logic m_en, m_enq, m_ack, m_err, m_out, m_apply;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: cycle %0d got %0d expected %0d", name, m_t, act, exp);
        end
    endtask

    function automatic logic m_edge();
        return ((m_t - m_o) % (m_r + 1)) == m_r;
    endfunction

    task automatic model_reset();
        m_t = 0; m_o = 0; m_r = int'(DEF_R); m_pend = 0; m_drains = 0;
        m_en = 0; m_enq = 0; m_ack = 0; m_err = 0; m_out = 0; m_apply = 0;
    endtask

    task automatic model_update(input logic v, input logic [2:0] d,
                                input logic idl, input logic ov);
        logic e, n_en, n_enq;
        e = m_edge();
        n_enq = m_en;
        m_ack = 0;
        m_err = 0;
        if (m_apply) begin
            n_en = ov;
            m_r = m_pend;
            m_o = m_t + 1;
            m_ack = 1;
            m_apply = 0;
            m_out = 0;
        end else begin
            n_en = e | ov;
            if (m_out) begin
                if (e) begin
                    if (idl) m_apply = 1;
                    else if (m_drains == DMAX - 1) begin
                        m_ack = 1; m_err = 1; m_out = 0;
                    end else m_drains++;
                end
            end else if (v) begin
                m_out = 1; m_pend = int'(d); m_drains = 0;
            end
        end
        m_en = n_en;
        m_enq = n_enq;
        m_t++;
    endtask

    task automatic check_all();
        chk("en",    int'(lsu_bus_clk_en),   int'(m_en));
        chk("en_q",  int'(lsu_bus_clk_en_q), int'(m_enq));
        chk("ratio", int'(bus_clk_ratio),    m_r);
        chk("ready", int'(ratio_wr_ready),   int'(!m_out));
        chk("ack",   int'(ratio_wr_ack),     int'(m_ack));
        chk("err",   int'(ratio_wr_err),     int'(m_err));
    endtask

    // Called at a negedge: drive inputs, compare this cycle, advance one clock.
    task automatic step(input logic v, input logic [2:0] d, input logic idl, input logic ov);
        ratio_wr_valid = v;
        ratio_wr_data  = d;
        lsu_bus_idle   = idl;
        clk_override   = ov;
        check_all();
        @(posedge clk);
        model_update(v, d, idl, ov);
        @(negedge clk);
    endtask

    // Issue a request then hold the given idle level until the ack, bounded.
    task automatic write_ratio(input logic [2:0] d, input logic idl, input string name);
        int k;
        step(1'b1, d, idl, 1'b0);
        k = 0;
        while (!ratio_wr_ack && k < 400) begin
            step(1'b0, 3'd0, idl, 1'b0);
            k++;
        end
        if (k >= 400) chk({name, "_ack_timeout"}, 0, 1);
    endtask

    initial begin
        int k;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_l = 1'b1;
        model_reset();

        // Reset cadence at ratio 3, pinned to literal cycle numbers.
        for (int t = 0; t < 15; t++) begin
            chk("lit_en",    int'(lsu_bus_clk_en),   int'(t == 4 || t == 8 || t == 12));
            chk("lit_en_q",  int'(lsu_bus_clk_en_q), int'(t == 5 || t == 9 || t == 13));
            chk("lit_ratio", int'(bus_clk_ratio), 3);
            step(1'b0, 3'd0, 1'b1, 1'b0);
        end

        // Ratio 3 -> 0 -> 2 with the bus idle, then observe the new cadence.
        write_ratio(3'd0, 1'b1, "w0");
        chk("lit_w0_err", int'(ratio_wr_err), 0);
        for (int i = 0; i < 4; i++) step(1'b0, 3'd0, 1'b1, 1'b0);
        write_ratio(3'd2, 1'b1, "w2");
        chk("lit_w2_ratio", int'(bus_clk_ratio), 2);
        chk("lit_w2_err", int'(ratio_wr_err), 0);
        for (int i = 0; i < 10; i++) step(1'b0, 3'd0, 1'b1, 1'b0);

        // Bus never idle: timeout rejection, ratio kept.
        write_ratio(3'd5, 1'b0, "tmo");
        chk("lit_tmo_err", int'(ratio_wr_err), 1);
        chk("lit_tmo_ratio", int'(bus_clk_ratio), 2);
        step(1'b0, 3'd0, 1'b1, 1'b0);
        chk("lit_tmo_ready", int'(ratio_wr_ready), 1);

        // Idle arrives exactly on the final drain edge: the change is applied.
        step(1'b1, 3'd1, 1'b0, 1'b0);
        k = 0;
        while (!ratio_wr_ack && k < 400) begin
            step(1'b0, 3'd0, (m_drains == DMAX - 1), 1'b0);
            k++;
        end
        if (k >= 400) chk("edge15_ack_timeout", 0, 1);
        chk("lit_edge15_err", int'(ratio_wr_err), 0);
        chk("lit_edge15_ratio", int'(bus_clk_ratio), 1);

        // Ratio 7, then override for 10 cycles during a busy drain.
        write_ratio(3'd7, 1'b1, "w7");
        step(1'b1, 3'd4, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 3'd0, 1'b0, (i < 10));
            if (i < 10) chk("lit_ovr_en", int'(lsu_bus_clk_en), 1);
        end
        k = 0;
        while (!ratio_wr_ack && k < 400) begin
            step(1'b0, 3'd0, 1'b0, 1'b0);
            k++;
        end
        if (k >= 400) chk("ovr_ack_timeout", 0, 1);
        chk("lit_ovr_err", int'(ratio_wr_err), 1);
        chk("lit_ovr_ratio", int'(bus_clk_ratio), 7);

        // Asynchronous reset in the middle of a drain.
        step(1'b1, 3'd6, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 3'd0, 1'b0, 1'b0);
        #2 rst_l = 1'b0;
        #1;
        chk("lit_rst_en",    int'(lsu_bus_clk_en), 0);
        chk("lit_rst_en_q",  int'(lsu_bus_clk_en_q), 0);
        chk("lit_rst_ratio", int'(bus_clk_ratio), 3);
        chk("lit_rst_ack",   int'(ratio_wr_ack), 0);
        chk("lit_rst_err",   int'(ratio_wr_err), 0);
        chk("lit_rst_ready", int'(ratio_wr_ready), 1);
        ratio_wr_valid = 1'b0;
        lsu_bus_idle = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_l = 1'b1;
        model_reset();
        for (int i = 0; i < 20; i++) step(1'b0, 3'd0, 1'b1, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 7) == 0), 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
